mul_wb_stage: RTL and testbench

Write-back and status stage directly downstream of the multiplier. It tracks the multiplier destination register across the multiplier's one-cycle execute latency and captures the 16-bit result for register-file write-back. It maintains the architectural multiplier status bits (ASTAT MN/MV, STKY MOS) from the multiplier flag outputs, and resolves read-after-write hazards for the following instructions by forwarding.

---
 rtl/mul_wb_stage.sv | 158 +++++++++++++++
 tb/tb_mul_wb_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mul_wb_stage.sv
// Multiplier write-back/status stage: E/W destination tracking, ASTAT/STKY flags, RAW forwarding.
// Define MUL_WB_FWD_EN for data forwarding; otherwise the block raises mul_ps_hazard to stall issue.
module mul_wb_stage #(
  parameter int RF_DATASIZE = 16,
  parameter int RF_ADDRSIZE = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ps_mul_en,
  input  logic                   ps_mul_otreg,
  input  logic [1:0]             ps_mul_cls,
  input  logic [1:0]             ps_mul_sc,
  input  logic [RF_ADDRSIZE-1:0] ps_mul_rn_addr,
  input  logic [RF_ADDRSIZE-1:0] ps_rx_addr,
  input  logic [RF_ADDRSIZE-1:0] ps_ry_addr,
  input  logic [RF_DATASIZE-1:0] mul_xb_dt,
  input  logic                   mul_ps_mv,
  input  logic                   mul_ps_mn,
  input  logic                   ps_stat_wr,
  input  logic [2:0]             ps_stat_wdt,
  output logic                   wb_rf_we,
  output logic [RF_ADDRSIZE-1:0] wb_rf_addr,
  output logic [RF_DATASIZE-1:0] wb_rf_dt,
  output logic                   astat_mn,
  output logic                   astat_mv,
  output logic                   stky_mos,
  output logic                   fwd_x,
  output logic                   fwd_y,
  output logic [RF_DATASIZE-1:0] fwd_x_dt,
  output logic [RF_DATASIZE-1:0] fwd_y_dt,
  output logic                   mul_ps_hazard
);

  logic                   e_en_q;
  logic                   e_otreg_q;
  logic [1:0]             e_cls_q;
  logic [1:0]             e_sc_q;
  logic [RF_ADDRSIZE-1:0] e_rn_addr_q;

  logic                   wb_we_q;
  logic [RF_ADDRSIZE-1:0] wb_addr_q;
  logic [RF_DATASIZE-1:0] wb_dt_q;

  logic mn_q, mv_q, mos_q;
  logic mn_d, mv_d, mos_d;

  logic e_rnwr;
  logic e_flagupd;
  logic x_hit_e, x_hit_w, y_hit_e, y_hit_w;

  assign e_rnwr    = e_en_q & ~e_otreg_q;
  // Plain MR0/1/2 transfers leave the flags alone; SAT MR updates them.
  assign e_flagupd = e_en_q & ~((e_cls_q == 2'b00) & (e_sc_q != 2'b11));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_en_q      <= 1'b0;
      e_otreg_q   <= 1'b0;
      e_cls_q     <= 2'b00;
      e_sc_q      <= 2'b00;
      e_rn_addr_q <= '0;
    end else begin
      e_en_q <= ps_mul_en;
      if (ps_mul_en) begin
        e_otreg_q   <= ps_mul_otreg;
        e_cls_q     <= ps_mul_cls;
        e_sc_q      <= ps_mul_sc;
        e_rn_addr_q <= ps_mul_rn_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_we_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_dt_q   <= '0;
    end else begin
      wb_we_q <= e_rnwr;
      if (e_rnwr) begin
        wb_addr_q <= e_rn_addr_q;
        wb_dt_q   <= mul_xb_dt;
      end
    end
  end

  // Hardware flags win over a sequencer write; a sticky set from hardware beats a software clear.
  always_comb begin
    mn_d  = mn_q;
    mv_d  = mv_q;
    mos_d = mos_q;
    if (e_flagupd) begin
      mn_d  = mul_ps_mn;
      mv_d  = mul_ps_mv;
      mos_d = (ps_stat_wr ? ps_stat_wdt[2] : mos_q) | mul_ps_mv;
    end else if (ps_stat_wr) begin
      mos_d = ps_stat_wdt[2];
      mv_d  = ps_stat_wdt[1];
      mn_d  = ps_stat_wdt[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mn_q  <= 1'b0;
      mv_q  <= 1'b0;
      mos_q <= 1'b0;
    end else begin
      mn_q  <= mn_d;
      mv_q  <= mv_d;
      mos_q <= mos_d;
    end
  end

  assign wb_rf_we   = wb_we_q;
  assign wb_rf_addr = wb_addr_q;
  assign wb_rf_dt   = wb_dt_q;
  assign astat_mn   = mn_q;
  assign astat_mv   = mv_q;
  assign stky_mos   = mos_q;

  assign x_hit_e = e_rnwr  & (ps_rx_addr == e_rn_addr_q);
  assign x_hit_w = wb_we_q & (ps_rx_addr == wb_addr_q);
  assign y_hit_e = e_rnwr  & (ps_ry_addr == e_rn_addr_q);
  assign y_hit_w = wb_we_q & (ps_ry_addr == wb_addr_q);

`ifdef MUL_WB_FWD_EN
  // E-stage result is newer than the W-stage one, so it takes priority.
  always_comb begin
    fwd_x    = 1'b0;
    fwd_x_dt = '0;
    fwd_y    = 1'b0;
    fwd_y_dt = '0;
    if (x_hit_e) begin
      fwd_x    = 1'b1;
      fwd_x_dt = mul_xb_dt;
    end else if (x_hit_w) begin
      fwd_x    = 1'b1;
      fwd_x_dt = wb_dt_q;
    end
    if (y_hit_e) begin
      fwd_y    = 1'b1;
      fwd_y_dt = mul_xb_dt;
    end else if (y_hit_w) begin
      fwd_y    = 1'b1;
      fwd_y_dt = wb_dt_q;
    end
  end
  assign mul_ps_hazard = 1'b0;
`else
  assign fwd_x         = 1'b0;
  assign fwd_y         = 1'b0;
  assign fwd_x_dt      = '0;
  assign fwd_y_dt      = '0;
  assign mul_ps_hazard = x_hit_e | x_hit_w | y_hit_e | y_hit_w;
`endif

endmodule

// File: tb/tb_mul_wb_stage.sv
// Bench for mul_wb_stage: write-backs checked through a scoreboard queue, status/forwarding checked inline.
module tb_mul_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        ps_mul_en, ps_mul_otreg;
  logic [1:0]  ps_mul_cls, ps_mul_sc;
  logic [3:0]  ps_mul_rn_addr, ps_rx_addr, ps_ry_addr;
  logic [15:0] mul_xb_dt;
  logic        mul_ps_mv, mul_ps_mn;
  logic        ps_stat_wr;
  logic [2:0]  ps_stat_wdt;
  logic        wb_rf_we;
  logic [3:0]  wb_rf_addr;
  logic [15:0] wb_rf_dt;
  logic        astat_mn, astat_mv, stky_mos;
  logic        fwd_x, fwd_y;
  logic [15:0] fwd_x_dt, fwd_y_dt;
  logic        mul_ps_hazard;

  int checks = 0;
  int errors = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  mul_wb_stage #(.RF_DATASIZE(16), .RF_ADDRSIZE(4)) dut (
    .clk(clk), .reset(reset),
    .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg),
    .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
    .ps_mul_rn_addr(ps_mul_rn_addr), .ps_rx_addr(ps_rx_addr), .ps_ry_addr(ps_ry_addr),
    .mul_xb_dt(mul_xb_dt), .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
    .ps_stat_wr(ps_stat_wr), .ps_stat_wdt(ps_stat_wdt),
    .wb_rf_we(wb_rf_we), .wb_rf_addr(wb_rf_addr), .wb_rf_dt(wb_rf_dt),
    .astat_mn(astat_mn), .astat_mv(astat_mv), .stky_mos(stky_mos),
    .fwd_x(fwd_x), .fwd_y(fwd_y), .fwd_x_dt(fwd_x_dt), .fwd_y_dt(fwd_y_dt),
    .mul_ps_hazard(mul_ps_hazard)
  );

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (wb_rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got addr=%0d dt=%h, required no write", wb_rf_addr, wb_rf_dt);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({wb_rf_addr, wb_rf_dt} !== e) begin
          errors++;
          $display("FAIL wb_write: got addr=%0d dt=%h, required addr=%0d dt=%h",
                   wb_rf_addr, wb_rf_dt, e[19:16], e[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ps_mul_en = 1'b0; ps_mul_otreg = 1'b0; ps_mul_cls = 2'b00; ps_mul_sc = 2'b00;
    ps_mul_rn_addr = 4'd0; ps_rx_addr = 4'd15; ps_ry_addr = 4'd15;
    mul_xb_dt = 16'h0000; mul_ps_mv = 1'b0; mul_ps_mn = 1'b0;
    ps_stat_wr = 1'b0; ps_stat_wdt = 3'b000;
  endtask

  task automatic issue(input logic otreg, input logic [1:0] cls, input logic [1:0] sc,
                       input logic [3:0] rn);
    ps_mul_en = 1'b1; ps_mul_otreg = otreg; ps_mul_cls = cls; ps_mul_sc = sc;
    ps_mul_rn_addr = rn;
  endtask

  task automatic exec(input logic [15:0] dt, input logic mv, input logic mn);
    mul_xb_dt = dt; mul_ps_mv = mv; mul_ps_mn = mn;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},   {15'd0, wb_rf_we}, 16'h0);
    chk({tag, "_addr"}, {12'd0, wb_rf_addr}, 16'h0);
    chk({tag, "_dt"},   wb_rf_dt, 16'h0);
    chk({tag, "_stat"}, {13'd0, stky_mos, astat_mv, astat_mn}, 16'h0);
    chk({tag, "_fwd"},  {14'd0, fwd_x, fwd_y}, 16'h0);
    chk({tag, "_fwdx"}, fwd_x_dt, 16'h0);
    chk({tag, "_fwdy"}, fwd_y_dt, 16'h0);
    chk({tag, "_haz"},  {15'd0, mul_ps_hazard}, 16'h0);
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();

    // Product to R3, mv=0 mn=1
    issue(1'b0, 2'b01, 2'b00, 4'd3); exp_q.push_back({4'd3, 16'h1234});
    tick(); idle(); exec(16'h1234, 1'b0, 1'b1);
    tick(); idle();
    #1 chk("t1_stat", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b001);

    // Accumulate to MR with mv=1: flags only, no write
    issue(1'b1, 2'b10, 2'b00, 4'd9);
    tick(); idle(); exec(16'hDEAD, 1'b1, 1'b0);
    tick(); idle();
    #1 chk("t2_stat", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b110);
    issue(1'b0, 2'b01, 2'b00, 4'd4); exp_q.push_back({4'd4, 16'h0AAA});
    tick(); idle(); exec(16'h0AAA, 1'b0, 1'b0);
    tick(); idle();
    #1 chk("t2_mos_sticky", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b100);

    // R5 = MR1: written, flags untouched despite mv/mn=1
    issue(1'b0, 2'b00, 2'b01, 4'd5); exp_q.push_back({4'd5, 16'h5555});
    tick(); idle(); exec(16'h5555, 1'b1, 1'b1);
    tick(); idle();
    #1 chk("t3_mr_xfer_stat", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b100);

    // Product to R2, Rx=R2 read in its E cycle, Ry=R2 read in its W cycle
    issue(1'b0, 2'b01, 2'b00, 4'd2); exp_q.push_back({4'd2, 16'hBEEF});
    tick(); idle(); exec(16'hBEEF, 1'b0, 1'b0); ps_rx_addr = 4'd2; ps_ry_addr = 4'd9;
    #1;
`ifdef MUL_WB_FWD_EN
    chk("t4_fwd_e", {14'd0, fwd_x, fwd_y}, 16'b10);
    chk("t4_fwd_e_dt", fwd_x_dt, 16'hBEEF);
`else
    chk("t4_haz_e", {15'd0, mul_ps_hazard}, 16'h1);
    chk("t4_fwd_tied_e", {14'd0, fwd_x, fwd_y}, 16'b00);
`endif
    tick(); idle(); ps_rx_addr = 4'd0; ps_ry_addr = 4'd2;
    #1;
`ifdef MUL_WB_FWD_EN
    chk("t4_fwd_w", {14'd0, fwd_x, fwd_y}, 16'b01);
    chk("t4_fwd_w_dt", fwd_y_dt, 16'hBEEF);
`else
    chk("t4_haz_w", {15'd0, mul_ps_hazard}, 16'h1);
    chk("t4_fwd_tied_w", fwd_y_dt, 16'h0);
`endif
    tick(); idle(); ps_rx_addr = 4'd2; ps_ry_addr = 4'd2;
    #1 chk("t4_no_hit", {13'd0, fwd_x, fwd_y, mul_ps_hazard}, 16'b000);

    // Back-to-back writes to R6: E-stage data wins over W-stage data
    issue(1'b0, 2'b01, 2'b00, 4'd6); exp_q.push_back({4'd6, 16'h1111});
    tick(); idle(); exec(16'h1111, 1'b0, 1'b0);
    issue(1'b0, 2'b11, 2'b00, 4'd6); exp_q.push_back({4'd6, 16'h2222});
    tick(); idle(); exec(16'h2222, 1'b0, 1'b1); ps_rx_addr = 4'd6;
    #1;
`ifdef MUL_WB_FWD_EN
    chk("t5_fwd_prio", fwd_x_dt, 16'h2222);
`else
    chk("t5_haz", {15'd0, mul_ps_hazard}, 16'h1);
`endif
    tick(); idle();
    #1 chk("t5_stat", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b101);

    // Software write alone clears MOS; idle cycle holds status
    ps_stat_wr = 1'b1; ps_stat_wdt = 3'b000;
    tick(); idle();
    #1 chk("t6_sw_clear", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b000);
    ps_stat_wr = 1'b1; ps_stat_wdt = 3'b011;
    tick(); idle();
    #1 chk("t6_sw_load", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b011);
    tick();
    #1 chk("t6_hold", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b011);

    // Software clear collides with hardware mv=1 to R8
    issue(1'b0, 2'b01, 2'b00, 4'd8); exp_q.push_back({4'd8, 16'h8888});
    tick(); idle(); exec(16'h8888, 1'b1, 1'b0); ps_stat_wr = 1'b1; ps_stat_wdt = 3'b000;
    tick(); idle();
    #1 chk("t7_collide", {13'd0, stky_mos, astat_mv, astat_mn}, 16'b110);

    // Reset during E of a product to R7: the write must be dropped
    issue(1'b0, 2'b01, 2'b00, 4'd7);
    tick(); idle(); exec(16'h7777, 1'b0, 1'b1);
    reset = 1'b0;
    #1 chk_all_zero("t8_in_reset");
    tick(); tick(); reset = 1'b1;
    tick(); tick(); tick();
    chk_all_zero("t8_after");

    tick();
    chk("queue_drained", exp_q.size(), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
